bram32_arbiter: RTL
===================

// Module: bram32_arbiter
// PURPOSE
//  Shares one single-port 32-bit synchronous BRAM (1-cycle read latency, read-before-write)
//  between two bus requesters (m0, m1; e.g. CPU data port and DMA engine).
//  Round-robin arbitration, classic stb/ack handshake, byte-lane writes via read-modify-write.
//  Out-of-window addresses are acked without touching the BRAM.
// PARAMETERS
//  adr_width  11  byte-address bits decoded by the BRAM; adr[15:adr_width]!=0 is out-of-range
// PORTS
//  sys_clk     in   1   system clock; all logic on rising edge
//  sys_rst     in   1   synchronous, active-low reset (0 = reset)
//  mN_stb      in   1   request (N=0,1); held with we/sel/adr/dat_w stable until mN_ack
//  mN_we       in   1   1 = write, 0 = read
//  mN_sel      in   4   byte enables for writes (sel[i] -> dat_w[8i+7:8i]); ignored on reads
//  mN_adr      in   16  byte address; [1:0] ignored
//  mN_dat_w    in   32  write data
//  mN_dat_r    out  32  read data, valid only while mN_ack=1
//  mN_ack      out  1   one-cycle completion pulse
//  bram_a      out  16  BRAM byte address (registered)
//  bram_di     out  32  BRAM write data (registered)
//  bram_we     out  1   BRAM write enable (registered, one-cycle pulse)
//  bram_do     in   32  BRAM read data, valid cycle after bram_a is presented
// BEHAVIOUR
//  Reset: state=IDLE, m0_ack=m1_ack=0, bram_we=0, bram_a=0, bram_di=0, last=1 (m0 wins first tie),
//   oor_q=0. mN_dat_r = (mN_ack && !oor_q) ? bram_do : 0.
//  States: IDLE, RD_WAIT, RMW_RD, RMW_MRG, ACK.
//  IDLE: no stb -> stay. Else grant g: only one stb -> that one; both -> g = ~last. last<=g.
//   Latch g, sel, dat_w; bram_a<=adr_g.
//   - out-of-range: oor_q<=1, -> ACK (ack next cycle, dat_r=0, no BRAM write).
//   - read: -> RD_WAIT.  - write, sel==4'hF: bram_di<=dat_w, bram_we<=1, -> ACK.
//   - write, sel==0: -> ACK (no-op write).  - write, partial sel: -> RMW_RD.
//  RD_WAIT: BRAM reads; -> ACK (ack registered). ACK cycle: dat_r = bram_do.
//  RMW_RD: BRAM reads old word; -> RMW_MRG.
//  RMW_MRG: bram_do valid; bram_di<=merge(bram_do,dat_w,sel), bram_we<=1; -> ACK.
//  ACK: mg_ack=1 one cycle; bram_we<=0, oor_q<=0; -> IDLE. Requester drops/changes stb at that edge.
//  Latency (stb seen in IDLE at T0 -> ack cycle): read T2; full write T1; partial write T3;
//   out-of-range T1. Min spacing between back-to-back grants: ack cycle + 1 IDLE.
//  Fairness: a requester with stb high waits at most one other transaction.
//  Both acks never high in the same cycle; non-granted ack stays 0; a stb that drops before
//   ack is a protocol violation (transaction still completes, ack still pulses).
//  Reset mid-transaction: all regs to reset values at that edge; in-flight transaction abandoned,
//   no ack. A bram_we already high in the reset cycle still commits at that edge (BRAM samples it).
//  bram_a holds its last value in IDLE; bram_we only high in the cycle the BRAM commits.
// STRUCTURE
//  Include bram32_arb_defs.vh: state localparams (3-bit), SEL_FULL=4'hF, SEL_NONE=4'h0.
//  Sub-module bram32_arb_rr: 2-way round-robin picker (stb0, stb1, last -> grant, valid).
//  Byte merge as a function in the top module; no other hierarchy.
// TESTING (bench drives real bram32-equivalent model, adr_width=11)
//  m0 read adr 0x0010 preloaded 0xDEADBEEF -> m0_ack 2 cycles after grant, m0_dat_r=0xDEADBEEF.
//  m1 write adr 0x0020 sel=F dat 0x12345678, then read -> ack 1 cycle after grant; read 0x12345678.
//  Word 0xAABBCCDD, m0 write sel=4'b0101 dat 0x11223344 -> bram_we single pulse, ack T3, word 0xAA22CC44.
//  m0,m1 stb together for 4 txns each -> grants m0,m1,m0,m1...; never two acks same cycle.
//  m1 read adr 0x0800 -> ack T1, m1_dat_r=0, bram_we never asserted; write 0x0FFC sel=0 -> no BRAM write.
//  sys_rst=0 during RMW_RD -> next cycle IDLE, no ack, target word unchanged; last=1 (m0 wins tie).

Source files
------------

// File: rtl/bram32_arbiter_pkg.sv
// Shared types and constants for the two-port BRAM arbiter.
package bram32_arbiter_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_RD_WAIT = 3'd1,
        ST_RMW_RD  = 3'd2,
        ST_RMW_MRG = 3'd3,
        ST_ACK     = 3'd4
    } state_t;

    localparam logic [3:0] SEL_FULL = 4'hF;
    localparam logic [3:0] SEL_NONE = 4'h0;

endpackage

// File: rtl/bram32_arb_rr.sv
// Two-way round-robin picker: a lone request wins outright, a tie goes to
// whichever requester was not granted last.
module bram32_arb_rr (
    input  logic stb0,
    input  logic stb1,
    input  logic last,
    output logic grant,
    output logic valid
);

    always_comb begin
        grant = 1'b0;
        valid = stb0 | stb1;
        if (stb0 && stb1) begin
            grant = ~last;
        end else if (stb1) begin
            grant = 1'b1;
        end
    end

endmodule

// File: rtl/bram32_arbiter.sv
// Shares one single-port 32-bit synchronous BRAM between two stb/ack requesters,
// with round-robin arbitration and read-modify-write for partial byte writes.
module bram32_arbiter
    import bram32_arbiter_pkg::*;
#(
    parameter int adr_width = 11
) (
    input  logic        sys_clk,
    input  logic        sys_rst,

    input  logic        m0_stb,
    input  logic        m0_we,
    input  logic [3:0]  m0_sel,
    input  logic [15:0] m0_adr,
    input  logic [31:0] m0_dat_w,
    output logic [31:0] m0_dat_r,
    output logic        m0_ack,

    input  logic        m1_stb,
    input  logic        m1_we,
    input  logic [3:0]  m1_sel,
    input  logic [15:0] m1_adr,
    input  logic [31:0] m1_dat_w,
    output logic [31:0] m1_dat_r,
    output logic        m1_ack,

    output logic [15:0] bram_a,
    output logic [31:0] bram_di,
    output logic        bram_we,
    input  logic [31:0] bram_do
);

    function automatic logic [31:0] merge_bytes(
        input logic [31:0] old_word,
        input logic [31:0] new_word,
        input logic [3:0]  sel
    );
        logic [31:0] res;
        res = old_word;
        for (int i = 0; i < 4; i++) begin
            if (sel[i]) begin
                res[8*i +: 8] = new_word[8*i +: 8];
            end
        end
        return res;
    endfunction

    state_t      state;
    logic        last;
    logic        gnt_q;
    logic        oor_q;
    logic [3:0]  sel_q;
    logic [31:0] dat_q;

    logic        gnt;
    logic        req_vld;
    logic        we_g;
    logic [3:0]  sel_g;
    logic [15:0] adr_g;
    logic [31:0] dat_g;
    logic        oor_g;

    bram32_arb_rr u_rr (
        .stb0  (m0_stb),
        .stb1  (m1_stb),
        .last  (last),
        .grant (gnt),
        .valid (req_vld)
    );

    assign we_g  = gnt ? m1_we    : m0_we;
    assign sel_g = gnt ? m1_sel   : m0_sel;
    assign adr_g = gnt ? m1_adr   : m0_adr;
    assign dat_g = gnt ? m1_dat_w : m0_dat_w;
    assign oor_g = (adr_g >> adr_width) != 16'd0;

    // Read data passes straight from the BRAM only in the ack cycle of an in-window access.
    assign m0_dat_r = (m0_ack && !oor_q) ? bram_do : 32'd0;
    assign m1_dat_r = (m1_ack && !oor_q) ? bram_do : 32'd0;

    // Write payload is captured at grant; it needs no reset.
    always_ff @(posedge sys_clk) begin
        if (state == ST_IDLE && req_vld) begin
            sel_q <= sel_g;
            dat_q <= dat_g;
        end
    end

    always_ff @(posedge sys_clk) begin
        if (!sys_rst) begin
            state   <= ST_IDLE;
            m0_ack  <= 1'b0;
            m1_ack  <= 1'b0;
            bram_we <= 1'b0;
            bram_a  <= 16'd0;
            bram_di <= 32'd0;
            last    <= 1'b1;
            oor_q   <= 1'b0;
            gnt_q   <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (req_vld) begin
                        last   <= gnt;
                        gnt_q  <= gnt;
                        bram_a <= adr_g;
                        if (oor_g) begin
                            oor_q  <= 1'b1;
                            m0_ack <= ~gnt;
                            m1_ack <= gnt;
                            state  <= ST_ACK;
                        end else if (!we_g) begin
                            state <= ST_RD_WAIT;
                        end else if (sel_g == SEL_FULL) begin
                            bram_di <= dat_g;
                            bram_we <= 1'b1;
                            m0_ack  <= ~gnt;
                            m1_ack  <= gnt;
                            state   <= ST_ACK;
                        end else if (sel_g == SEL_NONE) begin
                            m0_ack <= ~gnt;
                            m1_ack <= gnt;
                            state  <= ST_ACK;
                        end else begin
                            state <= ST_RMW_RD;
                        end
                    end
                end
                ST_RD_WAIT: begin
                    m0_ack <= ~gnt_q;
                    m1_ack <= gnt_q;
                    state  <= ST_ACK;
                end
                ST_RMW_RD: begin
                    state <= ST_RMW_MRG;
                end
                ST_RMW_MRG: begin
                    bram_di <= merge_bytes(bram_do, dat_q, sel_q);
                    bram_we <= 1'b1;
                    m0_ack  <= ~gnt_q;
                    m1_ack  <= gnt_q;
                    state   <= ST_ACK;
                end
                ST_ACK: begin
                    m0_ack  <= 1'b0;
                    m1_ack  <= 1'b0;
                    bram_we <= 1'b0;
                    oor_q   <= 1'b0;
                    state   <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
